// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and types for the BRAM port arbiter.
//   - default address/data widths
//   - arbiter FSM state encoding
//   - owner IDs for the two requesters (fetch, data)
package mem_arbiter_pkg;

   localparam int unsigned AddrWDefault = 14;
   localparam int unsigned DataWDefault = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMem  = 2'd1,
      StResp = 2'd2
   } marb_state_e;

   localparam logic OwnIf = 1'b0;
   localparam logic OwnD  = 1'b1;

   // Bit 0 = fetch, bit 1 = data.
   function automatic logic [1:0] own_onehot(input logic own);
      return (own == OwnD) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// mem_arbiter_rr_arb2: 2-way round-robin arbiter with last-winner pointer.
//   i_clk  clock
//   i_rst  synchronous active-high reset; pointer favours fetch afterwards
//   i_en   grants may only be issued while high
//   i_req  request vector (bit 0 = fetch, bit 1 = data)
//   o_gnt  one-hot combinational grant
module mem_arbiter_rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic last_q, last_d;

   always_comb begin
      o_gnt  = 2'b00;
      last_d = last_q;
      if (i_en) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // Tie: the port that did not win last time wins now.
            2'b11:   o_gnt = (last_q == OwnD) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
         endcase
      end
      if (o_gnt != 2'b00) begin
         last_d = o_gnt[1];
      end
   end

   // Reset value "data won last" makes fetch win the first tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q <= OwnD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed BRAM port between instruction fetch
// and data load/store, one access at a time, with round-robin fairness.
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_if_req/i_if_addr                fetch read request (held until gnt)
//   o_if_gnt/o_if_rvalid/o_if_rdata   fetch accept pulse, data valid, data
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata/i_d_wstrb               data request (held until gnt)
//   o_d_gnt/o_d_rvalid/o_d_rdata      data accept, completion, read data
//   o_mem_en/we/wstrb/addr/wdata      registered BRAM command
//   i_mem_rdata                       BRAM read data, one cycle after o_mem_en
// Timing: gnt at T, o_mem_en at T+1, rvalid at T+2; RESP overlaps next grant.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic [DATA_W-1:0]   i_d_wdata,
   input  logic [DATA_W/8-1:0] i_d_wstrb,
   output logic                o_d_gnt,
   output logic                o_d_rvalid,
   output logic [DATA_W-1:0]   o_d_rdata,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [DATA_W/8-1:0] o_mem_wstrb,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   marb_state_e state_q, state_d;
   logic        owner_q, owner_d;
   logic        wr_q, wr_d;

   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [1:0] req_mask;
   logic [1:0] req_vec;
   logic [1:0] gnt;
   logic       arb_en;
   logic       resp;

   // The owner of the completing access is still in flight during RESP.
   assign req_mask = (state_q == StResp) ? own_onehot(owner_q) : 2'b00;
   assign req_vec  = {i_d_req, i_if_req} & ~req_mask;
   assign arb_en   = !i_rst && (state_q != StMem);

   mem_arbiter_rr_arb2 u_rr_arb2 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (arb_en),
      .i_req (req_vec),
      .o_gnt (gnt)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_wstrb_d = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         StIdle, StResp: begin
            if (gnt[1]) begin
               state_d     = StMem;
               owner_d     = OwnD;
               wr_d        = i_d_we;
               mem_en_d    = 1'b1;
               mem_we_d    = i_d_we;
               mem_wstrb_d = i_d_we ? i_d_wstrb : '0;
               mem_addr_d  = i_d_addr;
               mem_wdata_d = i_d_wdata;
            end else if (gnt[0]) begin
               state_d     = StMem;
               owner_d     = OwnIf;
               wr_d        = 1'b0;
               mem_en_d    = 1'b1;
               mem_addr_d  = i_if_addr;
               mem_wdata_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StMem:   state_d = StResp;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         owner_q     <= OwnIf;
         wr_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wstrb_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign resp = (state_q == StResp);

   assign o_if_gnt    = gnt[0];
   assign o_d_gnt     = gnt[1];
   assign o_if_rvalid = resp && (owner_q == OwnIf);
   assign o_d_rvalid  = resp && (owner_q == OwnD);
   assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
   assign o_d_rdata   = (o_d_rvalid && !wr_q) ? i_mem_rdata : '0;

   assign o_mem_en    = mem_en_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_wstrb = mem_wstrb_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small BRAM model.
module tb_mem_arbiter;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_wstrb;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_wstrb;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [256];

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_gnt    (if_gnt),
      .o_if_rvalid (if_rvalid),
      .o_if_rdata  (if_rdata),
      .i_d_req     (d_req),
      .i_d_we      (d_we),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .i_d_wstrb   (d_wstrb),
      .o_d_gnt     (d_gnt),
      .o_d_rvalid  (d_rvalid),
      .o_d_rdata   (d_rdata),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_wstrb (mem_wstrb),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first BRAM with byte enables and one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr[7:0]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wstrb[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_if_gnt;
   logic [7:0] exp_d_gnt;
   logic       if_pend, d_pend;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'hFFFFFFFF;
      mem_rdata  = 32'h0;

      rst     = 1'b1;
      if_req  = 1'b1;
      if_addr = 14'h0010;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 14'h0020;
      d_wdata = 32'h12345678;
      d_wstrb = 4'b0011;

      // Reset held three cycles with both requests high.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check_val($sformatf("rst_gnt%0d", i), {62'd0, if_gnt, d_gnt}, 64'd0);
         check_val($sformatf("rst_cmd%0d", i), {44'd0, mem_en, mem_we, mem_wstrb, mem_addr}, 64'd0);
         check_val($sformatf("rst_wdata%0d", i), {32'd0, mem_wdata}, 64'd0);
         check_val($sformatf("rst_rsp%0d", i),
                   {if_rvalid, d_rvalid, |if_rdata, |d_rdata}, 64'd0);
      end

      // Release: fetch wins the tie, data write follows in the RESP slot.
      @(negedge clk); rst = 1'b0; #1;
      check_val("rel_if_gnt", {63'd0, if_gnt}, 64'd1);
      check_val("rel_d_gnt", {63'd0, d_gnt}, 64'd0);
      @(negedge clk); if_req = 1'b0; #1;
      check_val("f_mem_en", {63'd0, mem_en}, 64'd1);
      check_val("f_mem_addr", {50'd0, mem_addr}, 64'h10);
      check_val("f_mem_we", {59'd0, mem_we, mem_wstrb}, 64'd0);
      check_val("f_mem_dgnt", {63'd0, d_gnt}, 64'd0);
      @(negedge clk); #1;
      check_val("f_rvalid", {63'd0, if_rvalid}, 64'd1);
      check_val("f_rdata", {32'd0, if_rdata}, 64'hDEADBEEF);
      check_val("f_d_rvalid", {63'd0, d_rvalid}, 64'd0);
      check_val("w_gnt", {63'd0, d_gnt}, 64'd1);
      check_val("f_resp_en", {63'd0, mem_en}, 64'd0);
      @(negedge clk); d_req = 1'b0; #1;
      check_val("w_mem_en", {63'd0, mem_en}, 64'd1);
      check_val("w_mem_we", {59'd0, mem_we, mem_wstrb}, 64'h13);
      check_val("w_mem_addr", {50'd0, mem_addr}, 64'h20);
      check_val("w_mem_wdata", {32'd0, mem_wdata}, 64'h12345678);
      check_val("w_if_rvalid", {63'd0, if_rvalid}, 64'd0);
      @(negedge clk); #1;
      check_val("w_rvalid", {63'd0, d_rvalid}, 64'd1);
      check_val("w_rdata", {32'd0, d_rdata}, 64'd0);
      check_val("w_resp_we", {59'd0, mem_we, mem_wstrb}, 64'd0);

      // Data read back of the merged word.
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; #1;
      check_val("r_gnt", {63'd0, d_gnt}, 64'd1);
      @(negedge clk); d_req = 1'b0; #1;
      check_val("r_mem", {58'd0, mem_en, mem_we, mem_wstrb}, 64'h20);
      @(negedge clk); #1;
      check_val("r_rvalid", {63'd0, d_rvalid}, 64'd1);
      check_val("r_rdata", {32'd0, d_rdata}, 64'hFFFF5678);

      // Contention: grants alternate IF, D, IF, D every two cycles.
      exp_if_gnt = 8'h11;
      exp_d_gnt  = 8'h44;
      if_pend    = 1'b1;
      d_pend     = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); if_req = if_pend; d_req = d_pend; #1;
         check_val($sformatf("cont_if_gnt%0d", k), {63'd0, if_gnt}, {63'd0, exp_if_gnt[k]});
         check_val($sformatf("cont_d_gnt%0d", k), {63'd0, d_gnt}, {63'd0, exp_d_gnt[k]});
         if (if_gnt) if_pend = 1'b0;
         if (d_gnt) d_pend = 1'b0;
         if (if_rvalid) if_pend = 1'b1;
         if (d_rvalid) d_pend = 1'b1;
      end
      @(negedge clk); if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Overlap: data request raised during the MEM cycle of a fetch.
      @(negedge clk); if_req = 1'b1; #1;
      check_val("ov_if_gnt", {63'd0, if_gnt}, 64'd1);
      @(negedge clk); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; #1;
      check_val("ov_mem_dgnt", {62'd0, mem_en, d_gnt}, 64'h2);
      @(negedge clk); #1;
      check_val("ov_d_gnt", {62'd0, d_gnt, if_rvalid}, 64'h3);
      @(negedge clk); d_req = 1'b0; #1;
      check_val("ov_mem_en", {63'd0, mem_en}, 64'd1);
      check_val("ov_mem_addr", {50'd0, mem_addr}, 64'h20);
      @(negedge clk); #1;
      check_val("ov_d_rvalid", {63'd0, d_rvalid}, 64'd1);
      check_val("ov_d_rdata", {32'd0, d_rdata}, 64'hFFFF5678);

      // Zero-strobe write still takes a full slot.
      @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0000; #1;
      check_val("zs_gnt", {63'd0, d_gnt}, 64'd1);
      @(negedge clk); d_req = 1'b0; #1;
      check_val("zs_mem", {58'd0, mem_en, mem_we, mem_wstrb}, 64'h30);
      @(negedge clk); #1;
      check_val("zs_rvalid", {63'd0, d_rvalid}, 64'd1);
      @(negedge clk);

      // Reset during MEM of a fetch: access dropped, held request re-granted.
      @(negedge clk); if_req = 1'b1; #1;
      check_val("rm_gnt", {63'd0, if_gnt}, 64'd1);
      @(negedge clk); rst = 1'b1; #1;
      check_val("rm_mem_en", {63'd0, mem_en}, 64'd1);
      check_val("rm_no_gnt", {63'd0, if_gnt}, 64'd0);
      @(negedge clk); #1;
      check_val("rm_en_drop", {63'd0, mem_en}, 64'd0);
      check_val("rm_no_rvalid", {62'd0, if_rvalid, if_gnt}, 64'd0);
      @(negedge clk); rst = 1'b0; #1;
      check_val("rm_regnt", {63'd0, if_gnt}, 64'd1);
      @(negedge clk); if_req = 1'b0; #1;
      check_val("rm_mem_en2", {63'd0, mem_en}, 64'd1);
      @(negedge clk); #1;
      check_val("rm_rvalid", {63'd0, if_rvalid}, 64'd1);
      check_val("rm_rdata", {32'd0, if_rdata}, 64'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
